// File: rtl/cond_exec_ctrl_if.sv
// Issue / ALU-result / strobe bundle between the decode control FSM and the
// conditional-execution sequencer.
//   master : decode/control side (offers instructions, returns ALU results)
//   slave  : cond_exec_ctrl
interface cond_exec_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        op;
  logic [2:0]        cc;
  logic              fu;
  logic              alu_valid;
  logic [DATA_W-1:0] alu_out;
  logic              perform;
  logic              write_en;
  logic              abort;
  logic [2:0]        flags;
  logic              busy;

  modport master (
    output issue_valid, op, cc, fu, alu_valid, alu_out,
    input  issue_ready, perform, write_en, abort, flags, busy
  );

  modport slave (
    input  issue_valid, op, cc, fu, alu_valid, alu_out,
    output issue_ready, perform, write_en, abort, flags, busy
  );
endinterface

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution sequencer for the 16-bit CPU condition-flag unit.
// Accepts one instruction, evaluates its condition mask against the NZP
// flags, waits for the ALU result (with timeout), then emits registered
// one-cycle Perform/WriteEn/Abort strobes and optionally updates the flags.
//
// Optional build macro: CONDEXEC_FAST_ISSUE_EN
//   defined   : a new instruction may also be accepted in DONE, removing the
//               idle bubble between instructions.
//   undefined : instructions are accepted in IDLE only.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for an instruction
// WAIT_ALU | instruction latched, waiting for ALUValid or timeout
// DONE     | strobes visible for exactly this cycle
module cond_exec_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [2:0]  RESET_FLAGS = 3'b010
) (
  input  logic            i_clk,
  input  logic            i_rst,
  cond_exec_ctrl_if.slave io_ce
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ALU = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [7:0] CNT_MAX     = 8'hFF;
  localparam logic [3:0] OP_CPI      = 4'b0111;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_op;
  logic       r_fu;
  logic       r_cond;

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  logic [2:0] r_flags;
  logic [2:0] w_flags_nxt;

  logic       r_perform;
  logic       r_write_en;
  logic       r_abort;
  logic       w_perform_nxt;
  logic       w_write_en_nxt;
  logic       w_abort_nxt;

  logic       w_issue_ready;
  logic       w_accept;
  logic       w_cond_eval;
  logic       w_alu_n;
  logic       w_alu_z;
  logic [2:0] w_alu_flags;

`ifdef CONDEXEC_FAST_ISSUE_EN
  // DONE can overlap with the next accept; flags written on the edge that
  // entered DONE are already in r_flags, so condition evaluation is exact.
  assign w_issue_ready = (r_state == S_IDLE) || (r_state == S_DONE);
`else
  assign w_issue_ready = (r_state == S_IDLE);
`endif

  assign w_accept    = w_issue_ready & io_ce.issue_valid;

  // CC==000 means "always"; otherwise any selected flag set makes it true.
  assign w_cond_eval = (io_ce.cc == 3'b000) | (|(io_ce.cc & r_flags));

  // Result classification: exactly one of N/Z/P is ever set.
  assign w_alu_n     = io_ce.alu_out[DATA_W-1];
  assign w_alu_z     = (io_ce.alu_out == '0);
  assign w_alu_flags = {w_alu_n, w_alu_z, ~w_alu_n & ~w_alu_z};

  // Next-state, counter, flag and strobe computation.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_flags_nxt    = r_flags;
    w_perform_nxt  = 1'b0;
    w_write_en_nxt = 1'b0;
    w_abort_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT_ALU;
          w_cnt_nxt   = 8'd0;
        end
      end

      S_WAIT_ALU: begin
        // A result arriving on the timeout cycle still counts as success.
        if (io_ce.alu_valid) begin
          w_state_nxt    = S_DONE;
          w_perform_nxt  = r_cond;
          w_write_en_nxt = r_cond & (r_op != OP_CPI);
          if (r_cond & r_fu) begin
            w_flags_nxt = w_alu_flags;
          end
        end else if (r_cnt >= TIMEOUT_CNT) begin
          w_state_nxt = S_DONE;
          w_abort_nxt = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      S_DONE: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT_ALU;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter, flags and output strobes; reset drops any in-flight work.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_flags    <= RESET_FLAGS;
      r_perform  <= 1'b0;
      r_write_en <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_flags    <= w_flags_nxt;
      r_perform  <= w_perform_nxt;
      r_write_en <= w_write_en_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  // Capture the accepted instruction and its resolved condition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op   <= 4'd0;
      r_fu   <= 1'b0;
      r_cond <= 1'b0;
    end else if (w_accept) begin
      r_op   <= io_ce.op;
      r_fu   <= io_ce.fu;
      r_cond <= w_cond_eval;
    end
  end

  assign io_ce.issue_ready = w_issue_ready;
  assign io_ce.perform     = r_perform;
  assign io_ce.write_en    = r_write_en;
  assign io_ce.abort       = r_abort;
  assign io_ce.flags       = r_flags;
  assign io_ce.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Self-checking bench for cond_exec_ctrl: directed scenarios plus a random
// instruction stream, checked against an instruction-level flag model.
module tb_cond_exec_ctrl;

  localparam int         DATA_W      = 16;
  localparam int         TIMEOUT     = 15;
  localparam logic [2:0] RESET_FLAGS = 3'b010;
`ifdef CONDEXEC_FAST_ISSUE_EN
  localparam logic FAST = 1'b1;
`else
  localparam logic FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [2:0] m_flags = RESET_FLAGS;

  cond_exec_ctrl_if #(.DATA_W(DATA_W)) ce_if ();

  cond_exec_ctrl #(
    .DATA_W      (DATA_W),
    .TIMEOUT     (TIMEOUT),
    .RESET_FLAGS (RESET_FLAGS)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_ce (ce_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ce_if.issue_valid = 1'b0;
    ce_if.op          = 4'($urandom);
    ce_if.cc          = 3'($urandom);
    ce_if.fu          = 1'($urandom);
    ce_if.alu_valid   = 1'b0;
    ce_if.alu_out     = 16'($urandom);
  endtask

  // Issue one instruction (caller is just past a negedge with the DUT ready),
  // return ALUValid k cycles after accept (k > TIMEOUT+1 means never), and
  // return just past the negedge of the DONE cycle.
  task automatic do_instr(input logic [3:0] op, input logic [2:0] cc, input logic fu,
                          input logic [15:0] aout, input int k, input string tag);
    logic       cond;
    logic       tmo;
    int         j_end;
    logic       exp_perf;
    logic       exp_we;
    logic [2:0] old_flags;
    logic [2:0] new_flags;

    cond      = (cc == 3'b000) || ((cc & m_flags) != 3'b000);
    tmo       = (k > TIMEOUT + 1);
    j_end     = tmo ? TIMEOUT + 1 : k;
    exp_perf  = cond && !tmo;
    exp_we    = exp_perf && (op != 4'b0111);
    old_flags = m_flags;
    new_flags = m_flags;
    if (exp_perf && fu)
      new_flags = aout[15] ? 3'b100 : ((aout == 16'h0000) ? 3'b010 : 3'b001);

    checks++;
    if (ce_if.issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s issue_ready before accept: got %b expected 1", tag, ce_if.issue_ready);
    end
    ce_if.issue_valid = 1'b1;
    ce_if.op          = op;
    ce_if.cc          = cc;
    ce_if.fu          = fu;
    @(posedge clk);

    for (int j = 1; j <= j_end; j++) begin
      @(negedge clk);
      ce_if.issue_valid = 1'($urandom);
      ce_if.op          = 4'($urandom);
      ce_if.cc          = 3'($urandom);
      ce_if.fu          = 1'($urandom);
      ce_if.alu_valid   = (j == k);
      ce_if.alu_out     = (j == k) ? aout : 16'($urandom);
      checks++;
      if ({ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.write_en, ce_if.abort, ce_if.flags}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, old_flags}) begin
        failures++;
        $display("FAIL %s wait cycle %0d: busy/rdy/perf/we/abort/flags got %b%b%b%b%b %b expected 10000 %b",
                 tag, j, ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.write_en,
                 ce_if.abort, ce_if.flags, old_flags);
      end
      @(posedge clk);
    end

    @(negedge clk);
    ce_if.issue_valid = 1'b0;
    ce_if.alu_valid   = 1'($urandom);
    ce_if.alu_out     = 16'($urandom);
    checks++;
    if ({ce_if.perform, ce_if.write_en, ce_if.abort} !== {exp_perf, exp_we, tmo}) begin
      failures++;
      $display("FAIL %s strobes perf/we/abort: got %b%b%b expected %b%b%b", tag,
               ce_if.perform, ce_if.write_en, ce_if.abort, exp_perf, exp_we, tmo);
    end
    checks++;
    if ({ce_if.busy, ce_if.issue_ready, ce_if.flags} !== {1'b1, FAST, new_flags}) begin
      failures++;
      $display("FAIL %s done busy/rdy/flags: got %b%b %b expected 1%b %b", tag,
               ce_if.busy, ce_if.issue_ready, ce_if.flags, FAST, new_flags);
    end
    m_flags = new_flags;
  endtask

  task automatic go_idle();
    ce_if.issue_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.write_en, ce_if.abort, ce_if.flags}
        !== {5'b01000, m_flags}) begin
      failures++;
      $display("FAIL idle state busy/rdy/perf/we/abort/flags: got %b%b%b%b%b %b expected 01000 %b",
               ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.write_en, ce_if.abort,
               ce_if.flags, m_flags);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.write_en, ce_if.abort, ce_if.flags}
        !== {5'b01000, 3'b010}) begin
      failures++;
      $display("FAIL reset_async: busy/rdy/perf/we/abort/flags got %b%b%b%b%b %b expected 01000 010",
               ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.write_en, ce_if.abort, ce_if.flags);
    end
    #1 rst = 1'b0;
    m_flags = RESET_FLAGS;
    go_idle();
  endtask

  task automatic test_neg_update();
    do_instr(4'b0000, 3'b000, 1'b1, 16'hFFFF, 2, "neg_update");
    checks++;
    if ({ce_if.perform, ce_if.write_en, ce_if.flags} !== 5'b11_100) begin
      failures++;
      $display("FAIL neg_update literal perf/we/flags: got %b%b %b expected 11 100",
               ce_if.perform, ce_if.write_en, ce_if.flags);
    end
    go_idle();
  endtask

  task automatic test_cond_checks();
    do_instr(4'b0000, 3'b100, 1'b0, 16'($urandom), 1, "cc_n_true");
    checks++;
    if (ce_if.perform !== 1'b1) begin
      failures++;
      $display("FAIL cc_n_true perform: got %b expected 1", ce_if.perform);
    end
    go_idle();
    do_instr(4'b0001, 3'b001, 1'b0, 16'($urandom), 3, "cc_p_false");
    checks++;
    if ({ce_if.perform, ce_if.write_en} !== 2'b00) begin
      failures++;
      $display("FAIL cc_p_false perf/we: got %b%b expected 00", ce_if.perform, ce_if.write_en);
    end
    go_idle();
    do_instr(4'b0010, 3'b010, 1'b1, 16'h0000, 1, "cc_z_false_fu");
    checks++;
    if ({ce_if.perform, ce_if.flags} !== 4'b0_100) begin
      failures++;
      $display("FAIL cc_z_false_fu perf/flags: got %b %b expected 0 100", ce_if.perform, ce_if.flags);
    end
    go_idle();
  endtask

  task automatic test_compare();
    do_instr(4'b0111, 3'b111, 1'b1, 16'h0000, 2, "cpi");
    checks++;
    if ({ce_if.perform, ce_if.write_en, ce_if.flags} !== 5'b10_010) begin
      failures++;
      $display("FAIL cpi literal perf/we/flags: got %b%b %b expected 10 010",
               ce_if.perform, ce_if.write_en, ce_if.flags);
    end
    go_idle();
  endtask

  task automatic test_timeout();
    do_instr(4'b0001, 3'b000, 1'b1, 16'h1234, TIMEOUT + 2, "timeout");
    checks++;
    if ({ce_if.abort, ce_if.perform, ce_if.flags} !== 5'b10_010) begin
      failures++;
      $display("FAIL timeout literal abort/perf/flags: got %b%b %b expected 10 010",
               ce_if.abort, ce_if.perform, ce_if.flags);
    end
    go_idle();
    do_instr(4'b0011, 3'b000, 1'b0, 16'h0042, TIMEOUT + 1, "valid_at_timeout");
    checks++;
    if ({ce_if.abort, ce_if.perform} !== 2'b01) begin
      failures++;
      $display("FAIL valid_at_timeout abort/perf: got %b%b expected 01", ce_if.abort, ce_if.perform);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    do_instr(4'b0001, 3'b000, 1'b1, 16'h0005, 1, "b2b_first");
    if (!FAST) go_idle();
    do_instr(4'b0010, 3'b001, 1'b0, 16'($urandom), 1, "b2b_second");
    checks++;
    if ({ce_if.perform, ce_if.flags} !== 4'b1_001) begin
      failures++;
      $display("FAIL b2b_second perf/flags: got %b %b expected 1 001", ce_if.perform, ce_if.flags);
    end
    go_idle();
  endtask

  task automatic test_alu_ignored();
    ce_if.alu_valid = 1'b1;
    ce_if.alu_out   = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({ce_if.busy, ce_if.perform, ce_if.write_en, ce_if.abort, ce_if.flags}
          !== {4'b0000, m_flags}) begin
        failures++;
        $display("FAIL alu_ignored busy/perf/we/abort/flags: got %b%b%b%b %b expected 0000 %b",
                 ce_if.busy, ce_if.perform, ce_if.write_en, ce_if.abort, ce_if.flags, m_flags);
      end
    end
    ce_if.alu_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] aout;
    int          k;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'b0111 : 4'($urandom);
      case ($urandom_range(0, 3))
        0:       aout = 16'h0000;
        1:       aout = 16'h8000 | 16'($urandom);
        2:       aout = 16'h7FFF & 16'($urandom);
        default: aout = 16'($urandom);
      endcase
      k = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 + $urandom_range(0, 1) : $urandom_range(1, 4);
      do_instr(op, 3'($urandom), 1'($urandom), aout, k, "random");
      if (!(FAST && ($urandom_range(0, 1) == 1))) go_idle();
    end
    if (FAST) go_idle();
  endtask

  task automatic test_reset_mid_wait();
    do_instr(4'b0000, 3'b000, 1'b1, 16'h8000, 1, "pre_reset");
    go_idle();
    ce_if.issue_valid = 1'b1;
    ce_if.op          = 4'b0000;
    ce_if.cc          = 3'b000;
    ce_if.fu          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ce_if.issue_valid = 1'b0;
    ce_if.alu_valid   = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.abort, ce_if.flags}
        !== {4'b0100, RESET_FLAGS}) begin
      failures++;
      $display("FAIL reset_mid_wait busy/rdy/perf/abort/flags: got %b%b%b%b %b expected 0100 %b",
               ce_if.busy, ce_if.issue_ready, ce_if.perform, ce_if.abort, ce_if.flags, RESET_FLAGS);
    end
    @(negedge clk);
    ce_if.alu_valid = 1'b1;
    ce_if.alu_out   = 16'hFFFF;
    @(negedge clk);
    rst             = 1'b0;
    ce_if.alu_valid = 1'b0;
    m_flags         = RESET_FLAGS;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({ce_if.busy, ce_if.perform, ce_if.write_en, ce_if.flags} !== {3'b000, RESET_FLAGS}) begin
        failures++;
        $display("FAIL after_reset busy/perf/we/flags: got %b%b%b %b expected 000 %b",
                 ce_if.busy, ce_if.perform, ce_if.write_en, ce_if.flags, RESET_FLAGS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_neg_update();
    test_cond_checks();
    test_compare();
    test_timeout();
    test_back_to_back();
    test_alu_ignored();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
